// File: rtl/triangle_dispatch_queue.sv
// ============================================================================
// Module   : triangle_dispatch_queue
// Purpose  : FIFO between the vertex shader and N rasterizer lanes with
//            round-robin dispatch and mesh-completion tracking.
//            Optional macro BACKFACE_CULL_EN drops non-positive-area triangles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module triangle_dispatch_queue #(
    parameter int DEPTH     = 4,
    parameter int NUM_LANES = 2,
    parameter int XY_W      = 12,
    parameter int Z_W       = 21,
    parameter int COL_W     = 8,
    parameter int FACE_W    = 21,
    parameter int TRI_W     = 3*(2*XY_W+Z_W+COL_W)
) (
    input  logic                     clk,
    input  logic                     srst_n,
    input  logic                     start,
    input  logic [FACE_W-1:0]        num_of_faces,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TRI_W-1:0]         in_tri,
    output logic [NUM_LANES-1:0]     lane_valid,
    input  logic [NUM_LANES-1:0]     lane_ready,
    output logic [TRI_W-1:0]         lane_tri,
    input  logic [NUM_LANES-1:0]     lane_done,
    output logic                     busy,
    output logic                     finish,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef BACKFACE_CULL_EN
    ,
    output logic [FACE_W-1:0]        culled_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [FACE_W-1:0] r_num;
    logic [FACE_W-1:0] r_accepted;
    logic [FACE_W-1:0] r_retired;
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [TRI_W-1:0]  r_mem [DEPTH];
    logic [LW-1:0]     r_rr_ptr;

    logic              w_empty;
    logic              w_full;
    logic              w_active;
    logic              w_start;
    logic              w_push;
    logic              w_cull;
    logic              w_cull_push;
    logic              w_write;
    logic              w_pop;
    logic              w_found;
    logic [NUM_LANES-1:0] w_rot;
    logic [LW:0]       w_off;
    logic [LW:0]       w_sum;
    logic [LW-1:0]     w_sel;
    logic [LW:0]       w_sel_inc;
    logic [FACE_W:0]   w_inc;
    logic [FACE_W:0]   w_ret_sum;
    logic [FACE_W-1:0] w_ret_nxt;
    logic [FACE_W-1:0] w_acc_nxt;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_start  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    assign in_ready    = (r_state == S_RUN) && !w_full && (r_accepted < r_num);
    assign w_push      = in_valid && in_ready;
    assign w_cull_push = w_push && w_cull;
    assign w_write     = w_push && !w_cull;

`ifdef BACKFACE_CULL_EN
    localparam int VW = 2*XY_W + Z_W + COL_W;

    logic [XY_W-1:0]          w_x1, w_y1, w_x2, w_y2, w_x3, w_y3;
    logic signed [XY_W:0]     w_dx21, w_dy31, w_dx31, w_dy21;
    logic signed [2*XY_W+1:0] w_p1, w_p2;
    logic signed [2*XY_W+2:0] w_area;
    logic [FACE_W-1:0]        r_culled;

    assign w_x1 = in_tri[3*VW-1 -: XY_W];
    assign w_y1 = in_tri[3*VW-XY_W-1 -: XY_W];
    assign w_x2 = in_tri[2*VW-1 -: XY_W];
    assign w_y2 = in_tri[2*VW-XY_W-1 -: XY_W];
    assign w_x3 = in_tri[VW-1 -: XY_W];
    assign w_y3 = in_tri[VW-XY_W-1 -: XY_W];

    assign w_dx21 = $signed({1'b0, w_x2}) - $signed({1'b0, w_x1});
    assign w_dy31 = $signed({1'b0, w_y3}) - $signed({1'b0, w_y1});
    assign w_dx31 = $signed({1'b0, w_x3}) - $signed({1'b0, w_x1});
    assign w_dy21 = $signed({1'b0, w_y2}) - $signed({1'b0, w_y1});
    assign w_p1   = w_dx21 * w_dy31;
    assign w_p2   = w_dx31 * w_dy21;
    assign w_area = {w_p1[2*XY_W+1], w_p1} - {w_p2[2*XY_W+1], w_p2};
    assign w_cull = w_area[2*XY_W+2] || (w_area == '0);

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_culled <= '0;
        end else if (w_start) begin
            r_culled <= '0;
        end else if (w_cull_push && (r_culled != r_num)) begin
            r_culled <= r_culled + FACE_W'(1);
        end
    end

    assign culled_count = r_culled;
`else
    assign w_cull = 1'b0;
`endif

    // Round-robin: rotate the ready vector so the search always starts at bit 0.
    assign w_rot = NUM_LANES'({lane_ready, lane_ready} >> r_rr_ptr);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = (LW+1)'(i);
            end
        end
    end

    assign w_sum     = {1'b0, r_rr_ptr} + w_off;
    assign w_sel     = (w_sum >= (LW+1)'(NUM_LANES)) ? LW'(w_sum - (LW+1)'(NUM_LANES))
                                                     : LW'(w_sum);
    assign w_sel_inc = {1'b0, w_sel} + (LW+1)'(1);
    assign w_pop     = !w_empty && w_found;

    assign lane_valid = w_pop ? (NUM_LANES'(1) << w_sel) : '0;
    assign lane_tri   = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign fifo_level = r_wr_ptr - r_rd_ptr;
    assign busy       = w_active;
    assign finish     = (r_state == S_DONE);

    // A culled triangle retires in the same cycle it is accepted.
    always_comb begin
        w_inc = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_inc = w_inc + (FACE_W+1)'(lane_done[i]);
        end
        if (w_cull_push) begin
            w_inc = w_inc + (FACE_W+1)'(1);
        end
        if (!w_active) begin
            w_inc = '0;
        end
    end

    assign w_ret_sum = {1'b0, r_retired} + w_inc;
    assign w_ret_nxt = (w_ret_sum >= {1'b0, r_num}) ? r_num : w_ret_sum[FACE_W-1:0];
    assign w_acc_nxt = (w_push && (r_accepted != r_num)) ? r_accepted + FACE_W'(1)
                                                         : r_accepted;

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_state    <= S_IDLE;
            r_num      <= '0;
            r_accepted <= '0;
            r_retired  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_num      <= num_of_faces;
                        r_accepted <= '0;
                        r_retired  <= '0;
                        r_state    <= (num_of_faces == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    r_accepted <= w_acc_nxt;
                    r_retired  <= w_ret_nxt;
                    if (w_acc_nxt == r_num) begin
                        r_state <= S_DRAIN;
                    end
                end
                default: begin
                    r_accepted <= w_acc_nxt;
                    r_retired  <= w_ret_nxt;
                    if (w_ret_nxt == r_num) begin
                        r_state <= S_DONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
                r_rr_ptr <= (w_sel_inc == (LW+1)'(NUM_LANES)) ? '0 : LW'(w_sel_inc);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_tri;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_triangle_dispatch_queue.sv
// ============================================================================
// Module   : tb_triangle_dispatch_queue
// Purpose  : Bench for triangle_dispatch_queue against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_triangle_dispatch_queue;

    localparam int DEPTH  = 4;
    localparam int NL     = 2;
    localparam int XY_W   = 12;
    localparam int Z_W    = 21;
    localparam int COL_W  = 8;
    localparam int FACE_W = 21;
    localparam int VW     = 2*XY_W + Z_W + COL_W;
    localparam int TRI_W  = 3*VW;

    logic                 clk;
    logic                 srst_n;
    logic                 start;
    logic [FACE_W-1:0]    num_of_faces;
    logic                 in_valid;
    logic                 in_ready;
    logic [TRI_W-1:0]     in_tri;
    logic [NL-1:0]        lane_valid;
    logic [NL-1:0]        lane_ready;
    logic [TRI_W-1:0]     lane_tri;
    logic [NL-1:0]        lane_done;
    logic                 busy;
    logic                 finish;
    logic [$clog2(DEPTH):0] fifo_level;
`ifdef BACKFACE_CULL_EN
    logic [FACE_W-1:0]    culled_count;
`endif

    triangle_dispatch_queue #(
        .DEPTH(DEPTH), .NUM_LANES(NL), .XY_W(XY_W), .Z_W(Z_W),
        .COL_W(COL_W), .FACE_W(FACE_W)
    ) u_dut (
        .clk(clk), .srst_n(srst_n), .start(start), .num_of_faces(num_of_faces),
        .in_valid(in_valid), .in_ready(in_ready), .in_tri(in_tri),
        .lane_valid(lane_valid), .lane_ready(lane_ready), .lane_tri(lane_tri),
        .lane_done(lane_done), .busy(busy), .finish(finish),
        .fifo_level(fifo_level)
`ifdef BACKFACE_CULL_EN
        , .culled_count(culled_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0=idle 1=run 2=drain 3=done
    logic [TRI_W-1:0] q[$];
    int m_phase, m_num, m_acc, m_ret, m_cull, m_rr, pending;
    int n_chk, n_bad;
    logic          obs_ir, obs_busy;
    logic [NL-1:0] obs_lv;
    int            obs_lvl;

    task automatic chk(input string tag, input logic [TRI_W-1:0] obs, input logic [TRI_W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TRI_W-1:0] mk(input int x1, input int y1, input int x2,
                                             input int y2, input int x3, input int y3);
        logic [VW-1:0] v1, v2, v3;
        v1 = {XY_W'(x1), XY_W'(y1), Z_W'($urandom), COL_W'($urandom)};
        v2 = {XY_W'(x2), XY_W'(y2), Z_W'($urandom), COL_W'($urandom)};
        v3 = {XY_W'(x3), XY_W'(y3), Z_W'($urandom), COL_W'($urandom)};
        return {v1, v2, v3};
    endfunction

    function automatic logic [TRI_W-1:0] mk_rand();
        return mk($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095),
                  $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095));
    endfunction

    function automatic bit is_culled(input logic [TRI_W-1:0] t);
`ifdef BACKFACE_CULL_EN
        int x1, y1, x2, y2, x3, y3, area;
        x1 = int'(t[3*VW-1 -: XY_W]); y1 = int'(t[3*VW-XY_W-1 -: XY_W]);
        x2 = int'(t[2*VW-1 -: XY_W]); y2 = int'(t[2*VW-XY_W-1 -: XY_W]);
        x3 = int'(t[VW-1 -: XY_W]);   y3 = int'(t[VW-XY_W-1 -: XY_W]);
        area = (x2 - x1) * (y3 - y1) - (x3 - x1) * (y2 - y1);
        return area <= 0;
`else
        return t[0] && !t[0];
`endif
    endfunction

    // One clock: drive at negedge, check outputs against the model, advance the model.
    task automatic step(input bit st, input int nf, input bit iv, input logic [TRI_W-1:0] t,
                        input logic [NL-1:0] rdy, input logic [NL-1:0] dn);
        bit exp_ir;
        int sel, inc, l;
        logic [NL-1:0] exp_lv;
        logic [TRI_W-1:0] exp_tri;
        @(negedge clk);
        start = st; num_of_faces = FACE_W'(nf); in_valid = iv; in_tri = t;
        lane_ready = rdy; lane_done = dn;
        #1;
        exp_ir = (m_phase == 1) && (q.size() < DEPTH) && (m_acc < m_num);
        sel = -1;
        for (int k = 0; k < NL; k++) begin
            l = (m_rr + k) % NL;
            if (sel < 0 && rdy[l]) sel = l;
        end
        exp_lv  = (q.size() > 0 && sel >= 0) ? NL'(1 << sel) : '0;
        exp_tri = (q.size() > 0) ? q[0] : '0;
        obs_ir = in_ready; obs_lv = lane_valid; obs_lvl = int'(fifo_level); obs_busy = busy;
        chk("in_ready",   TRI_W'(in_ready),   TRI_W'(exp_ir));
        chk("lane_valid", TRI_W'(lane_valid), TRI_W'(exp_lv));
        chk("lane_tri",   lane_tri,           exp_tri);
        chk("fifo_level", TRI_W'(fifo_level), TRI_W'(q.size()));
        chk("busy",       TRI_W'(busy),       TRI_W'(m_phase == 1 || m_phase == 2));
        chk("finish",     TRI_W'(finish),     TRI_W'(m_phase == 3));
`ifdef BACKFACE_CULL_EN
        chk("culled_count", TRI_W'(culled_count), TRI_W'(m_cull));
`endif
        if (exp_lv != '0) begin
            void'(q.pop_front());
            pending++;
            m_rr = (sel + 1) % NL;
        end
        if (st && (m_phase == 0 || m_phase == 3)) begin
            m_num = nf; m_acc = 0; m_ret = 0; m_cull = 0;
            m_phase = (nf == 0) ? 3 : 1;
        end else if (m_phase == 1 || m_phase == 2) begin
            inc = $countones(dn);
            pending -= inc;
            if (iv && exp_ir) begin
                m_acc++;
                if (is_culled(t)) begin
                    m_cull++;
                    inc++;
                end else begin
                    q.push_back(t);
                end
            end
            m_ret = (m_ret + inc > m_num) ? m_num : m_ret + inc;
            if (m_phase == 1 && m_acc == m_num) m_phase = 2;
            else if (m_phase == 2 && m_ret == m_num) m_phase = 3;
        end
    endtask

    task automatic idle(input logic [NL-1:0] rdy);
        step(1'b0, 0, 1'b0, '0, rdy, '0);
    endtask

    task automatic apply_reset(input logic [NL-1:0] rdy);
        @(negedge clk);
        lane_ready = rdy; start = 1'b0; in_valid = 1'b0; lane_done = '0;
        srst_n = 1'b0;
        #1;
        chk("rst_fifo_level", TRI_W'(fifo_level), '0);
        chk("rst_lane_valid", TRI_W'(lane_valid), '0);
        chk("rst_finish",     TRI_W'(finish),     '0);
        chk("rst_busy",       TRI_W'(busy),       '0);
        chk("rst_in_ready",   TRI_W'(in_ready),   '0);
        chk("rst_lane_tri",   lane_tri,           '0);
        q.delete();
        m_phase = 0; m_num = 0; m_acc = 0; m_ret = 0; m_cull = 0; m_rr = 0; pending = 0;
        @(negedge clk);
        srst_n = 1'b1;
    endtask

    task automatic rand_done(output logic [NL-1:0] d);
        int p;
        p = pending;
        d = '0;
        for (int i = 0; i < NL; i++) begin
            if (p > 0 && $urandom_range(0, 2) == 0) begin
                d[i] = 1'b1;
                p--;
            end
        end
    endtask

    task automatic run_mesh(input int nf);
        logic [NL-1:0] d;
        int cyc;
        step(1'b1, nf, 1'b0, '0, '0, '0);
        cyc = 0;
        while (m_phase != 3 && cyc < 400) begin
            rand_done(d);
            step(1'b0, 0, ($urandom_range(0, 9) < 7), mk_rand(), NL'($urandom), d);
            cyc++;
        end
        idle('0);
        chk("mesh_finish", TRI_W'(finish), TRI_W'(1));
    endtask

    initial begin
        n_chk = 0; n_bad = 0;
        srst_n = 1'b0; start = 1'b0; num_of_faces = '0; in_valid = 1'b0;
        in_tri = '0; lane_ready = '0; lane_done = '0;
        repeat (2) @(posedge clk);
        apply_reset('0);

        // Zero-face mesh completes immediately without opening the input.
        step(1'b1, 0, 1'b1, mk(0, 0, 10, 0, 0, 10), '0, '0);
        idle('0);
        chk("zero_finish", TRI_W'(finish), TRI_W'(1));
        chk("zero_in_ready", TRI_W'(obs_ir), '0);

        // Lanes blocked: only DEPTH of six offered triangles get in.
        step(1'b1, 6, 1'b0, '0, '0, '0);
        for (int k = 0; k < 6; k++) step(1'b0, 0, 1'b1, mk(0, 0, 10 + k, 0, 0, 10), '0, '0);
        chk("full_level", TRI_W'(obs_lvl), TRI_W'(4));
        chk("full_in_ready", TRI_W'(obs_ir), '0);
        // Both lanes ready: strict alternation starting at lane 0.
        for (int k = 0; k < 4; k++) begin
            idle(2'b11);
            chk($sformatf("rr_order%0d", k), TRI_W'(obs_lv), TRI_W'((k % 2 == 0) ? 2'b01 : 2'b10));
        end
        for (int k = 0; k < 2; k++) step(1'b0, 0, 1'b1, mk(0, 0, 20 + k, 0, 0, 10), '0, '0);
        idle(2'b11); idle(2'b11);
        step(1'b0, 0, 1'b0, '0, '0, 2'b11);
        step(1'b0, 0, 1'b0, '0, '0, 2'b11);
        step(1'b0, 0, 1'b0, '0, '0, 2'b11);
        idle('0);
        chk("six_finish", TRI_W'(finish), TRI_W'(1));

        // Five faces retired with a same-cycle pair of done pulses.
        step(1'b1, 5, 1'b0, '0, '0, '0);
        for (int k = 0; k < 5; k++) step(1'b0, 0, 1'b1, mk(0, 0, 30 + k, 0, 0, 10), 2'b11, '0);
        idle(2'b11); idle(2'b11);
        step(1'b0, 0, 1'b0, '0, '0, 2'b11);
        step(1'b0, 0, 1'b0, '0, '0, 2'b01);
        step(1'b0, 0, 1'b0, '0, '0, 2'b10);
        idle('0);
        chk("five_not_yet", TRI_W'(finish), '0);
        step(1'b0, 0, 1'b0, '0, '0, 2'b01);
        idle('0);
        chk("five_finish", TRI_W'(finish), TRI_W'(1));

        // Reset while draining with three entries queued.
        step(1'b1, 3, 1'b0, '0, '0, '0);
        for (int k = 0; k < 3; k++) step(1'b0, 0, 1'b1, mk(0, 0, 40 + k, 0, 0, 10), '0, '0);
        idle('0);
        chk("drain_level", TRI_W'(obs_lvl), TRI_W'(3));
        chk("drain_busy", TRI_W'(obs_busy), TRI_W'(1));
        apply_reset(2'b11);

`ifdef BACKFACE_CULL_EN
        step(1'b1, 2, 1'b0, '0, '0, '0);
        step(1'b0, 0, 1'b1, mk(0, 0, 0, 10, 10, 0), 2'b11, '0);
        idle(2'b11);
        chk("cull_count", TRI_W'(culled_count), TRI_W'(1));
        chk("cull_not_sent", TRI_W'(obs_lv), '0);
        step(1'b0, 0, 1'b1, mk(0, 0, 10, 0, 0, 10), 2'b11, '0);
        idle(2'b11);
        chk("keep_sent", TRI_W'(obs_lv != '0), TRI_W'(1));
        step(1'b0, 0, 1'b0, '0, '0, 2'b01);
        idle('0);
        chk("cull_finish", TRI_W'(finish), TRI_W'(1));
`endif

        for (int m = 0; m < 8; m++) run_mesh($urandom_range(1, 12));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
